// File: rtl/mult_sched_defs.sv
// Shared defaults for the round-robin multiplier scheduler.
`ifndef MULT_SCHED_DEFS_SV
`define MULT_SCHED_DEFS_SV

`define MSD_CLOG2(x) $clog2(x)

package mult_sched_defs;
  localparam int unsigned MSD_W    = 4;
  localparam int unsigned MSD_NREQ = 4;
  localparam int unsigned MSD_IDW  = `MSD_CLOG2(MSD_NREQ);
  localparam int unsigned MSD_CNTW = 16;
  localparam int unsigned MSD_PW   = 2 * MSD_W;
endpackage

`endif

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
  import mult_sched_defs::*;
#(
  parameter int unsigned NREQ = MSD_NREQ,
  parameter int unsigned IDW  = MSD_IDW
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  // Scan ptr, ptr+1, ... modulo NREQ and grant the first active request.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      logic [IDW-1:0] idx;
      idx = IDW'((32'(ptr) + k) % NREQ);
      if (en && !gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one WxW multiplier among NREQ requesters via a two-stage pipeline.
module mult_rr_scheduler
  import mult_sched_defs::*;
#(
  parameter int unsigned W    = MSD_W,
  parameter int unsigned NREQ = MSD_NREQ,
  parameter int unsigned IDW  = MSD_IDW,
  parameter int unsigned CNTW = MSD_CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*W-1:0]    out_prod,
  output logic [IDW-1:0]    out_id,
  output logic [CNTW-1:0]   op_count,
  output logic              busy
);

  localparam int unsigned PW = 2 * W;

  logic           s1_valid;
  logic [W-1:0]   s1_a;
  logic [W-1:0]   s1_b;
  logic [IDW-1:0] s1_id;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] ptr_nxt;

  logic           adv1;
  logic           adv2;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;
  logic [PW-1:0]  prod;

  logic [W-1:0] a_arr [NREQ];
  logic [W-1:0] b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*W +: W];
    assign b_arr[g] = req_b[g*W +: W];
  end

  assign adv2 = !out_valid || out_ready;
  assign adv1 = !s1_valid || adv2;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .en      (adv1 && !rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;
  assign ptr_nxt   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Stand-in for the mapped multiplier core; full-width unsigned product.
  assign prod = PW'(s1_a) * PW'(s1_b);

  // Stage 1: capture the granted operands and move the priority pointer past the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      rr_ptr   <= '0;
    end else if (adv1) begin
      s1_valid <= gnt_any;
      if (gnt_any) begin
        s1_a   <= a_arr[gnt_idx];
        s1_b   <= b_arr[gnt_idx];
        s1_id  <= gnt_idx;
        rr_ptr <= ptr_nxt;
      end
    end
  end

  // Stage 2: product register, frozen while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_id    <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_prod <= prod;
        out_id   <= s1_id;
      end
    end
  end

  // Count completed output transfers, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (out_valid && out_ready) begin
      op_count <= op_count + 1'b1;
    end
  end

  assign busy = s1_valid || out_valid;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed and random checks of mult_rr_scheduler against a transaction-level model.
module tb_mult_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        out_ready;

  logic [3:0]  req_ready,  req_ready4;
  logic        out_valid,  out_valid4;
  logic [7:0]  out_prod,   out_prod4;
  logic [1:0]  out_id,     out_id4;
  logic [15:0] op_count;
  logic [3:0]  op_count4;
  logic        busy,       busy4;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned prod;
    int unsigned id;
    int unsigned t;
  } item_t;

  item_t       q[$];
  int          rr  = 0;
  int unsigned cnt = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;

  mult_rr_scheduler #(.W(4), .NREQ(4), .IDW(2), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_id(out_id), .op_count(op_count), .busy(busy)
  );

  mult_rr_scheduler #(.W(4), .NREQ(4), .IDW(2), .CNTW(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready4), .out_valid(out_valid4), .out_ready(out_ready),
    .out_prod(out_prod4), .out_id(out_id4), .op_count(op_count4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int exp_grant(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (p + k) % 4;
      if (v[j[1:0]]) return j;
    end
    return -1;
  endfunction

  task automatic set_op(input int i, input int unsigned a, input int unsigned b);
    req_a[i*4 +: 4] = 4'(a);
    req_b[i*4 +: 4] = 4'(b);
  endtask

  // One clock: predict, compare, then retire/admit transactions in the model.
  task automatic step();
    int       g;
    logic [3:0] er;
    bit       ov, adv1, adv2;
    int       ns1;
    item_t    it;
    #1;
    ov   = (q.size() > 0) && (cyc >= q[0].t + 2);
    ns1  = q.size() - (ov ? 1 : 0);
    adv2 = !ov || out_ready;
    adv1 = (ns1 == 0) || adv2;
    g    = (adv1 && !rst) ? exp_grant(req_valid, rr) : -1;
    er   = (g >= 0) ? 4'(1 << g) : 4'b0;
    check("req_ready", 32'(req_ready), 32'(er));
    check("req_ready_c4", 32'(req_ready4), 32'(er));
    check("out_valid", 32'(out_valid), 32'(ov));
    check("out_valid_c4", 32'(out_valid4), 32'(ov));
    if (ov) begin
      check("out_prod", 32'(out_prod), q[0].prod);
      check("out_id", 32'(out_id), q[0].id);
      check("out_prod_c4", 32'(out_prod4), q[0].prod);
    end
    check("busy", 32'(busy), 32'(q.size() > 0));
    check("busy_c4", 32'(busy4), 32'(q.size() > 0));
    check("op_count", 32'(op_count), cnt & 32'hFFFF);
    check("op_count_c4", 32'(op_count4), cnt & 32'hF);
    @(posedge clk);
    if (rst) begin
      q.delete();
      rr  = 0;
      cnt = 0;
    end else begin
      if (ov && out_ready) begin
        void'(q.pop_front());
        cnt++;
      end
      if (g >= 0) begin
        it.prod = ((32'(req_a) >> (4 * g)) & 32'hF) * ((32'(req_b) >> (4 * g)) & 32'hF);
        it.id   = 32'(g);
        it.t    = cyc;
        q.push_back(it);
        rr = (g + 1) % 4;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; out_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Reset while an operation is in flight: 3*5 must never emerge.
    req_valid = 4'b0001; set_op(0, 3, 5);
    step();
    req_valid = 4'b0000; rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rst_out_prod", 32'(out_prod), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    req_valid = 4'b0011; set_op(1, 2, 3);
    step();
    req_valid = 4'b0000;
    idle(4);

    // Single requester latency: 15*15 from requester 2.
    req_valid = 4'b0100; set_op(2, 15, 15);
    step();
    req_valid = 4'b0000;
    idle(4);

    // All four contend continuously: strict rotation, one result per cycle.
    for (int i = 0; i < 4; i++) set_op(i, 32'(i + 1), 2);
    req_valid = 4'b1111;
    idle(8);
    req_valid = 4'b0000;
    idle(3);

    // Backpressure with both stages occupied.
    req_valid = 4'b1111; out_ready = 1'b0;
    idle(5);
    req_valid = 4'b0000; out_ready = 1'b1;
    idle(4);

    // Boundary operands through requester 1.
    req_valid = 4'b0010;
    set_op(1, 0, 15);  step();
    set_op(1, 15, 0);  step();
    set_op(1, 1, 1);   step();
    set_op(1, 8, 8);   step();
    req_valid = 4'b0000;
    idle(3);

    // Counter wrap: 17 transfers from reset, narrow counter goes 15 -> 0 -> 1.
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = 4'b1111;
    idle(17);
    req_valid = 4'b0000;
    idle(3);
    check("wrap_final_c4", 32'(op_count4), 32'd1);
    check("wrap_final", 32'(op_count), 32'd17);

    // Random traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      req_valid = 4'($urandom);
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; req_valid = '0; out_ready = 1'b1;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
